// File: rtl/simple_pkg.sv
// Shared definitions for the 16-bit SIMPLE pipeline.
// Provides datapath width, register-field positions, NOP word and fetch FSM states.
package simple_pkg;

    localparam int unsigned DATA_W = 16;

    // Register-field positions inside an instruction word
    localparam int unsigned RA_MSB = 13;
    localparam int unsigned RA_LSB = 11;
    localparam int unsigned RB_MSB = 10;
    localparam int unsigned RB_LSB = 8;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds instruction, PC+1 and valid bit.
// Ports: clk, rst (async high), bubble (load NOP, highest priority), hold,
//        instr_in/pc1_in (loaded when neither bubble nor hold),
//        instr/pc1/valid outputs.
module if_id_reg
    import simple_pkg::*;
#(
    parameter int unsigned       W   = DATA_W,
    parameter logic [W-1:0]      NOP = NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic         hold,
    input  logic [W-1:0] instr_in,
    input  logic [W-1:0] pc1_in,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc1,
    output logic         valid
);

    logic [W-1:0] instr_q, instr_d;
    logic [W-1:0] pc1_q, pc1_d;
    logic         valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP;
            pc1_d   = '0;
            valid_d = 1'b0;
        end else if (!hold) begin
            instr_d = instr_in;
            pc1_d   = pc1_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc1   = pc1_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with PC, RUN/HALT FSM and IF/ID register.
// Ports: clk, rst (async high); pc_stop (0 = stall), branch_taken/branch_target,
//        halt_req, resume; imem_addr/imem_rdata to instruction memory;
//        if_id_instr/pc1/valid/ra/rb to decode; halted status.
// Optional macro IF_STALL_CNT_EN adds a saturating stall_cnt[15:0] output.
module if_stage
    import simple_pkg::*;
#(
    parameter int unsigned          DATA_W    = simple_pkg::DATA_W,
    parameter logic [DATA_W-1:0]    RESET_PC  = '0,
    parameter logic [DATA_W-1:0]    NOP_INSTR = simple_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_stop,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc1,
    output logic              if_id_valid,
    output logic [2:0]        if_id_ra,
    output logic [2:0]        if_id_rb,
`ifdef IF_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] pc_plus1;
    logic              ifid_hold;
    logic              ifid_bubble;
    logic              stall_hit;

    assign pc_plus1 = pc_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_hold   = 1'b1;
        ifid_bubble = 1'b0;
        stall_hit   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_d        = branch_target;
                    ifid_bubble = 1'b1;
                end else if (halt_req) begin
                    state_d     = HALT;
                    ifid_bubble = 1'b1;
                end else if (!pc_stop) begin
                    stall_hit   = 1'b1;
                end else begin
                    pc_d        = pc_plus1;
                    ifid_hold   = 1'b0;
                end
            end
            HALT: begin
                // Everything frozen; resume re-enters RUN and the
                // next edge fetches from the held pc.
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_hit && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = stall_hit;
`endif

    if_id_reg #(
        .W   (DATA_W),
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .bubble   (ifid_bubble),
        .hold     (ifid_hold),
        .instr_in (imem_rdata),
        .pc1_in   (pc_plus1),
        .instr    (if_id_instr),
        .pc1      (if_id_pc1),
        .valid    (if_id_valid)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);

    // Raw slices; stale during a bubble, consumers qualify with valid.
    assign if_id_ra = if_id_instr[RA_MSB:RA_LSB];
    assign if_id_rb = if_id_instr[RB_MSB:RB_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Instruction memory model returns 16'h1000 + address.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stop;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_req;
    logic        resume;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc1;
    logic        if_id_valid;
    logic [2:0]  if_id_ra;
    logic [2:0]  if_id_rb;
    logic        halted;
`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 16'h1000 + imem_addr;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_stop       (pc_stop),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid),
        .if_id_ra      (if_id_ra),
        .if_id_rb      (if_id_rb),
`ifdef IF_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .halted        (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_stop = 1'b1; branch_taken = 1'b0;
        branch_target = '0; halt_req = 1'b0; resume = 1'b0;
        #3;
        n_cmp++;
        if (imem_addr !== 16'h0000) begin
            n_bad++; $display("FAIL reset_pc got %h exp 0000", imem_addr);
        end
        n_cmp++;
        if (if_id_instr !== 16'h0000 || if_id_pc1 !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_ifid got %h/%h exp 0000/0000", if_id_instr, if_id_pc1);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got v=%b h=%b exp 0/0", if_id_valid, halted);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (if_id_instr !== 16'h1000 + 16'(i) ||
                if_id_pc1 !== 16'(i + 1) || if_id_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL fetch%0d got %h/%h/%b exp %h/%h/1", i,
                         if_id_instr, if_id_pc1, if_id_valid,
                         16'h1000 + 16'(i), 16'(i + 1));
            end
        end
        n_cmp++;
        if (imem_addr !== 16'd3) begin
            n_bad++; $display("FAIL fetch_addr got %h exp 0003", imem_addr);
        end
        n_cmp++;
        if (if_id_ra !== 3'd2 || if_id_rb !== 3'd0) begin
            n_bad++; $display("FAIL fetch_fields got %0d/%0d exp 2/0", if_id_ra, if_id_rb);
        end
    endtask

    task automatic test_stall();
        step(); step();
        pc_stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (imem_addr !== 16'd5 || if_id_instr !== 16'h1004 ||
                if_id_pc1 !== 16'd5 || if_id_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall%0d got %h/%h/%h exp 0005/1004/0005", i,
                         imem_addr, if_id_instr, if_id_pc1);
            end
        end
`ifdef IF_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'd2) begin
            n_bad++; $display("FAIL stall_cnt got %0d exp 2", stall_cnt);
        end
`endif
        pc_stop = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 16'd6 || if_id_instr !== 16'h1005 || if_id_pc1 !== 16'd6) begin
            n_bad++;
            $display("FAIL stall_release got %h/%h/%h exp 0006/1005/0006",
                     imem_addr, if_id_instr, if_id_pc1);
        end
    endtask

    task automatic test_branch();
        step(); step();
        branch_taken = 1'b1; branch_target = 16'h0040; pc_stop = 1'b0;
        halt_req = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 16'h0040 || if_id_valid !== 1'b0 ||
            if_id_instr !== 16'h0000 || if_id_pc1 !== 16'h0000 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL branch got %h/%b/%h/%h/%b exp 0040/0/0000/0000/0",
                     imem_addr, if_id_valid, if_id_instr, if_id_pc1, halted);
        end
`ifdef IF_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'd2) begin
            n_bad++; $display("FAIL branch_cnt got %0d exp 2", stall_cnt);
        end
`endif
        halt_req = 1'b0; pc_stop = 1'b1; branch_target = 16'd10;
        step();
        branch_taken = 1'b0;
        n_cmp++;
        if (imem_addr !== 16'd10) begin
            n_bad++; $display("FAIL branch2 got %h exp 000a", imem_addr);
        end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        n_cmp++;
        if (halted !== 1'b1 || imem_addr !== 16'd10 || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_enter got h=%b %h v=%b exp 1/000a/0",
                     halted, imem_addr, if_id_valid);
        end
        for (int i = 0; i < 5; i++) begin
            branch_taken  = (i % 2 == 0);
            branch_target = 16'h0077;
            pc_stop       = (i % 3 != 0);
            halt_req      = (i == 3);
            step();
            n_cmp++;
            if (halted !== 1'b1 || imem_addr !== 16'd10 || if_id_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_hold%0d got h=%b %h v=%b exp 1/000a/0",
                         i, halted, imem_addr, if_id_valid);
            end
        end
        branch_taken = 1'b0; halt_req = 1'b0; pc_stop = 1'b1;
        resume = 1'b1;
        step();
        resume = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || imem_addr !== 16'd10 || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL resume got h=%b %h v=%b exp 0/000a/0",
                     halted, imem_addr, if_id_valid);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        n_cmp++;
        if (if_id_instr !== 16'h100A || if_id_pc1 !== 16'd11 ||
            imem_addr !== 16'd11 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL post_resume got %h/%h/%h h=%b exp 100a/000b/000b/0",
                     if_id_instr, if_id_pc1, imem_addr, halted);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        step();
        n_cmp++;
        if (if_id_pc1 !== 16'h0000 || imem_addr !== 16'h0000 ||
            if_id_instr !== 16'h0FFF || if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap got %h/%h/%h exp 0000/0000/0fff",
                     if_id_pc1, imem_addr, if_id_instr);
        end
    endtask

    task automatic test_rst_mid_stall();
        branch_taken = 1'b1; branch_target = 16'd7;
        step();
        branch_taken = 1'b0; pc_stop = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_addr !== 16'h0000 || if_id_instr !== 16'h0000 ||
            if_id_pc1 !== 16'h0000 || if_id_valid !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async got %h/%h/%h v=%b h=%b exp zeros",
                     imem_addr, if_id_instr, if_id_pc1, if_id_valid, halted);
        end
`ifdef IF_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_bad++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0; pc_stop = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 16'd1 || if_id_instr !== 16'h1000 || if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_run got %h/%h v=%b exp 0001/1000/1",
                     imem_addr, if_id_instr, if_id_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_halt();
        test_wrap();
        test_rst_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit SIMPLE pipeline.
- Holds the PC, presents the fetch address to instruction memory and latches the returned instruction into IF/ID.
- Drives the IF_ID_RegisterRa/Rb fields consumed by the load-use hazard unit, and obeys that unit's pc_stop (0 = hold).
- Applies branch flush and a RUN/HALT state machine.

Parameters:
- DATA_W, 16, instruction/PC width.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, instruction word loaded into IF/ID on a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pc_stop  in  1  from hazard unit; 0 = stall (hold PC and IF/ID), 1 = advance.
- branch_taken  in  1  branch resolved taken this cycle.
- branch_target  in  DATA_W  new PC when branch_taken=1.
- halt_req  in  1  ID decoded a valid HLT.
- resume  in  1  single-cycle pulse; leaves HALT.
- imem_addr  out  DATA_W  combinational = pc register.
- imem_rdata  in  DATA_W  combinational instruction-memory read of imem_addr.
- if_id_instr  out  DATA_W  latched instruction.
- if_id_pc1  out  DATA_W  latched PC+1 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- if_id_ra  out  3  if_id_instr[13:11] (IF_ID_RegisterRa).
- if_id_rb  out  3  if_id_instr[10:8] (IF_ID_RegisterRb).
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc1=0, if_id_valid=0, state=RUN, halted=0.
- States: RUN, HALT. Each rising edge in RUN, evaluated in priority order:
  1. branch_taken=1: pc<=branch_target; IF/ID <= bubble (NOP_INSTR, pc1=0, valid=0). Overrides pc_stop=0 and halt_req.
  2. halt_req=1: state<=HALT; pc holds; IF/ID <= bubble.
  3. pc_stop=0: pc, if_id_instr, if_id_pc1 and if_id_valid all hold unchanged.
  4. Otherwise: pc<=pc+1 (mod 2^DATA_W; 16'hFFFF wraps to 0); if_id_instr<=imem_rdata; if_id_pc1<=pc+1; if_id_valid<=1.
- In HALT:
  - pc and IF/ID hold.
  - branch_taken, pc_stop and halt_req are ignored.
  - resume=1: state<=RUN. The first fetch happens on the next edge from the held pc.
  - resume while in RUN is ignored.
- Latency: instruction at address A appears on if_id_instr one edge after pc=A with pc_stop=1.
- halted = (state==HALT), registered.
- if_id_ra/if_id_rb are pure slices of the register and carry stale fields during a bubble. Consumers qualify with if_id_valid.
- Reset mid-stall or mid-halt returns to the reset values above.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0]; reset 0.
  - Increments on each edge in RUN where rule 3 applies; saturates at 16'hFFFF.
  - Cleared by rst only.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package (simple_pkg):
  - DATA_W, RA_MSB/RA_LSB (13/11), RB_MSB/RB_LSB (10/8).
  - NOP_INSTR default.
  - typedef fetch_state_t {RUN, HALT}.
- One natural sub-module: if_id_reg, holding instr/pc1/valid with hold and bubble controls. The PC and FSM stay in if_stage.

Test Plan:
- Reset then 3 free-running edges with imem returning 16'h1000+addr: if_id_instr 16'h1000, 16'h1001, 16'h1002; if_id_pc1 1, 2, 3; valid=1; imem_addr=3.
- pc=5, pc_stop=0 for 2 cycles: pc stays 5, IF/ID unchanged. Release: instr at 5 latched, pc=6. With IF_STALL_CNT_EN: stall_cnt=2.
- pc=8, branch_taken=1, target=16'h0040, pc_stop=0 simultaneously: pc=16'h0040, if_id_valid=0, if_id_instr=NOP_INSTR.
- halt_req at pc=10: halted=1, pc holds 10 for 5 cycles despite branch_taken pulses. resume pulse: next fetch from 10, halted=0.
- pc=16'hFFFF, advance: if_id_pc1=0, pc=0.
- Assert rst mid-stall at pc=7: outputs are at reset values immediately, without waiting for a clock edge; state=RUN.
